pe_load_sequencer: RTL

Sequencer feeding one processing element's kernel and neuron local stores and then driving its multiply-accumulate phase. It accepts a valid/ready word stream from the global buffer, writes the first `len` words into the kernel store and the next `len` words into the neuron store, then sweeps read addresses 0..len-1 across both stores with MAC-enable strobes. It is the writer and sequencer end of the local-store interface that the PE's store controller reads from.

---
 rtl/pe_pkg.sv | 17 +
 rtl/pe_load_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pe_pkg.sv
// Shared types and default widths for the PE load sequencer.
// No logic here, so no latency.
// No flow control here.
package pe_pkg;

    localparam int W = 16;  // data word width
    localparam int A = 7;   // local-store address width

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_K,
        S_LOAD_N,
        S_COMPUTE,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/pe_load_sequencer.sv
// Loads len words into the kernel store, then len into the neuron store, then sweeps both for MAC.
// Latency: write strobes are combinational from srcValid; a job takes 3*len+2 cycles, from start to done, when the stream never stalls.
// Backpressure: srcReady is high only while loading; srcValid gaps stall the counter.
module pe_load_sequencer #(
    parameter int W = pe_pkg::W,
    parameter int A = pe_pkg::A
) (
    input  logic         CLK,
    input  logic         RESETn,
    input  logic         start,
    input  logic [A:0]   len,
    input  logic         srcValid,
    input  logic [W-1:0] srcData,
    output logic         srcReady,
    output logic [A-1:0] kernelAddr,
    output logic [W-1:0] kernelData,
    output logic         kernelWrite,
    output logic [A-1:0] neuronAddr,
    output logic [W-1:0] neuronData,
    output logic         neuronWrite,
    output logic         macEn,
    output logic         macFirst,
    output logic         busy,
    output logic         done
);
    import pe_pkg::*;

    localparam logic [A:0] ONE = {{A{1'b0}}, 1'b1};

    seq_state_t state_q, state_d;
    // cnt is one bit wider than the address so len = 2^A never wraps
    logic [A:0] cnt_q, cnt_d;
    logic [A:0] len_q, len_d;
    logic [A:0] cnt_inc;
    logic       last;

    assign cnt_inc = cnt_q + ONE;
    // cnt has reached len-1; only consulted in states where len_q >= 1
    assign last    = (cnt_inc == len_q);

    // State, counter and latched length registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    // Next-state logic and all outputs; outputs default to 0 so IDLE/DONE drive zeros
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        srcReady    = 1'b0;
        kernelAddr  = '0;
        kernelData  = '0;
        kernelWrite = 1'b0;
        neuronAddr  = '0;
        neuronData  = '0;
        neuronWrite = 1'b0;
        macEn       = 1'b0;
        macFirst    = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    len_d   = len;
                    cnt_d   = '0;
                    state_d = (len == '0) ? S_DONE : S_LOAD_K;
                end
            end

            S_LOAD_K: begin
                srcReady    = 1'b1;
                kernelAddr  = cnt_q[A-1:0];
                kernelData  = srcData;
                kernelWrite = srcValid;
                if (srcValid) begin
                    if (last) begin
                        cnt_d   = '0;
                        state_d = S_LOAD_N;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            S_LOAD_N: begin
                srcReady    = 1'b1;
                neuronAddr  = cnt_q[A-1:0];
                neuronData  = srcData;
                neuronWrite = srcValid;
                if (srcValid) begin
                    if (last) begin
                        cnt_d   = '0;
                        state_d = S_COMPUTE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            S_COMPUTE: begin
                // Stores are read at cnt; the PE consumes the data one cycle later
                kernelAddr = cnt_q[A-1:0];
                neuronAddr = cnt_q[A-1:0];
                macEn      = 1'b1;
                macFirst   = (cnt_q == '0);
                if (last) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_DONE: begin
                // One cycle after the last MAC, so the final read is covered
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
